// File: rtl/fractal_sync_1d_local_ctrl.sv
// fractal_sync_1d_local_ctrl
//   Per-port request controller sitting in front of the 1D local sync RF.
//   Each port buffers barrier requests in a small FIFO, issues one RF check
//   per request, parks in WAIT until a partner port's check finds the barrier
//   present, and returns one response (id + err) per request, in order.
//
// Parameters
//   N_REGS      RF barrier registers (must match the RF instance)
//   ID_WIDTH    barrier id width, local id = id[ID_WIDTH-1:1] (>= 2)
//   N_PORTS     request ports (>= 2)
//   FIFO_DEPTH  request FIFO entries per port (power of two, >= 2)
//
// Ports (all per-port vectors are indexed [N_PORTS-1:0])
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o/req_id_i  request push (ready = FIFO not full)
//   resp_valid_o/resp_ready_i         response handshake
//   resp_id_o/resp_err_o              completed id, invalid-id flag
//   rf_check_o/rf_id_o                RF check strobe and id
//   rf_present_i/rf_id_err_i/
//   rf_bypass_i/rf_ignore_i           same-cycle RF results
//
// Optional build macro FRACTAL_SYNC_LOCAL_CTRL_STATS_EN adds
//   sync_cnt_o (32b, wrapping count of good responses) and
//   err_cnt_o  (16b, saturating count of error responses) per port.
module fractal_sync_1d_local_ctrl #(
  parameter int unsigned N_REGS     = 1,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_PORTS-1:0]                 req_valid_i,
  output logic [N_PORTS-1:0]                 req_ready_o,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   req_id_i,
  output logic [N_PORTS-1:0]                 resp_valid_o,
  input  logic [N_PORTS-1:0]                 resp_ready_i,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]   resp_id_o,
  output logic [N_PORTS-1:0]                 resp_err_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]   rf_id_o,
  output logic [N_PORTS-1:0]                 rf_check_o,
  input  logic [N_PORTS-1:0]                 rf_present_i,
  input  logic [N_PORTS-1:0]                 rf_id_err_i,
  input  logic [N_PORTS-1:0]                 rf_bypass_i,
  input  logic [N_PORTS-1:0]                 rf_ignore_i
`ifdef FRACTAL_SYNC_LOCAL_CTRL_STATS_EN
  ,
  output logic [N_PORTS-1:0][31:0]           sync_cnt_o,
  output logic [N_PORTS-1:0][15:0]           err_cnt_o
`endif
);

  localparam int unsigned LID_W = ID_WIDTH - 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_e;

  // Cross-port view used to release waiters.
  logic [N_PORTS-1:0]            chk_present, waiting, wake;
  logic [N_PORTS-1:0][LID_W-1:0] chk_lid, wait_lid;

  // A present hit on local id L releases whichever other port is parked on L.
  // The RF holds one bit per id, so at most one port can match.
  always_comb begin
    wake = '0;
    for (int p = 0; p < N_PORTS; p++)
      for (int q = 0; q < N_PORTS; q++)
        if (q != p && waiting[p] && chk_present[q] &&
            chk_lid[q] == wait_lid[p] && 32'(chk_lid[q]) < N_REGS)
          wake[p] = 1'b1;
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [FIFO_DEPTH-1:0][ID_WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    state_e              state_q, state_d;
    logic [LID_W-1:0]    wlid_q, wlid_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d, head;
    logic                rerr_q, rerr_d, push, pop;

    assign head           = mem_q[rd_ptr_q];
    assign req_ready_o[p] = !rst_i && (cnt_q != FULL);
    assign push           = req_valid_i[p] && req_ready_o[p];
    assign pop            = (state_q == CHECK);
    assign cnt_d          = cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign chk_present[p] = pop && rf_present_i[p];
    assign chk_lid[p]     = head[ID_WIDTH-1:1];
    assign waiting[p]     = (state_q == WAIT);
    assign wait_lid[p]    = wlid_q;

    // IDLE/RESP look at cnt_d so a push in this cycle is checked next cycle.
    always_comb begin
      state_d = state_q;
      wlid_d  = wlid_q;
      rid_d   = rid_q;
      rerr_d  = rerr_q;
      case (state_q)
        IDLE:  if (cnt_d != '0) state_d = CHECK;
        CHECK: begin
          rid_d   = head;
          rerr_d  = 1'b0;
          state_d = RESP;
          if (rf_id_err_i[p]) rerr_d = 1'b1;
          else if (!(rf_present_i[p] || rf_bypass_i[p] || rf_ignore_i[p])) begin
            state_d = WAIT;
            wlid_d  = head[ID_WIDTH-1:1];
          end
        end
        WAIT:  if (wake[p]) state_d = RESP;
        RESP:  if (resp_ready_i[p]) state_d = (cnt_d != '0) ? CHECK : IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q  <= IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        wlid_q   <= '0;
        rid_q    <= '0;
        rerr_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        wlid_q  <= wlid_d;
        rid_q   <= rid_d;
        rerr_q  <= rerr_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end

    // Storage only; emptiness is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= req_id_i[p];
    end

    assign rf_check_o[p]   = pop;
    assign rf_id_o[p]      = pop ? head : '0;
    assign resp_valid_o[p] = (state_q == RESP);
    assign resp_id_o[p]    = resp_valid_o[p] ? rid_q : '0;
    assign resp_err_o[p]   = resp_valid_o[p] && rerr_q;

`ifdef FRACTAL_SYNC_LOCAL_CTRL_STATS_EN
    logic        hs;
    logic [31:0] sync_q;
    logic [15:0] errc_q;

    assign hs = resp_valid_o[p] && resp_ready_i[p];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q <= '0;
        errc_q <= '0;
      end else if (hs) begin
        if (!rerr_q)                  sync_q <= sync_q + 32'd1;
        else if (errc_q != 16'hFFFF)  errc_q <= errc_q + 16'd1;
      end
    end

    assign sync_cnt_o[p] = sync_q;
    assign err_cnt_o[p]  = errc_q;
`endif
  end

endmodule

// File: tb/tb_fractal_sync_1d_local_ctrl.sv
// Bench for fractal_sync_1d_local_ctrl with 3 ports, 2 RF registers, 3-bit ids.
// A small RF stand-in answers checks: out-of-range local id -> id_err; a
// registered waiter -> present for the first checker; several checkers on one
// free id -> bypass/ignore pairing; a lone checker registers itself as waiter.
// A transaction model (per-port request queues, expected response queues,
// who-is-waiting-on-what) predicts every output each cycle.
module tb_fractal_sync_1d_local_ctrl;
  localparam int NP = 3, IW = 3, NR = 2, FD = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]         req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [NP-1:0]         rf_check, rf_present, rf_id_err, rf_bypass, rf_ignore;
  logic [NP-1:0][IW-1:0] req_id, resp_id, rf_id;
`ifdef FRACTAL_SYNC_LOCAL_CTRL_STATS_EN
  logic [NP-1:0][31:0]   sync_cnt;
  logic [NP-1:0][15:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  fractal_sync_1d_local_ctrl #(.N_REGS(NR), .ID_WIDTH(IW), .N_PORTS(NP), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_err_o(resp_err),
    .rf_id_o(rf_id), .rf_check_o(rf_check),
    .rf_present_i(rf_present), .rf_id_err_i(rf_id_err),
    .rf_bypass_i(rf_bypass), .rf_ignore_i(rf_ignore)
`ifdef FRACTAL_SYNC_LOCAL_CTRL_STATS_EN
    , .sync_cnt_o(sync_cnt), .err_cnt_o(err_cnt)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RF stand-in ----------------
  logic [3:0] rf_bits;
  int s_tot, s_early;

  always_comb begin
    rf_present = '0; rf_id_err = '0; rf_bypass = '0; rf_ignore = '0;
    s_tot = 0; s_early = 0;
    for (int p = 0; p < NP; p++) begin
      if (rf_check[p]) begin
        if (int'(rf_id[p][IW-1:1]) >= NR) rf_id_err[p] = 1'b1;
        else begin
          s_tot = 0; s_early = 0;
          for (int q = 0; q < NP; q++)
            if (rf_check[q] && rf_id[q][IW-1:1] == rf_id[p][IW-1:1]) begin
              s_tot++;
              if (q < p) s_early++;
            end
          if (rf_bits[rf_id[p][IW-1:1]]) begin
            if (s_early == 0) rf_present[p] = 1'b1; else rf_bypass[p] = 1'b1;
          end else if (s_tot >= 2) begin
            if (s_early == 0) rf_bypass[p] = 1'b1; else rf_ignore[p] = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) rf_bits <= '0;
    else
      for (int p = 0; p < NP; p++)
        if (rf_check[p] && !rf_id_err[p]) begin
          if (rf_present[p]) rf_bits[rf_id[p][IW-1:1]] <= 1'b0;
          else if (!rf_bypass[p] && !rf_ignore[p]) rf_bits[rf_id[p][IW-1:1]] <= 1'b1;
        end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int            cnt[NP];
  bit            waiting[NP], rnext[NP], nxt[NP], pv[NP], pr[NP];
  logic [IW-2:0] wlid[NP];
  logic [IW-1:0] fifo_m[NP][$];
  logic [IW:0]   exp_q[NP][$];   // {err, id}
  bit            started = 0, rst_prev = 0, ev;
  logic [IW-1:0] hd;

  always @(negedge clk) begin
    if (started) begin
      for (int p = 0; p < NP; p++) begin
        ev = rnext[p] || (pv[p] && !pr[p]);
        chk("req_ready", int'(req_ready[p]), int'(cnt[p] < FD && !rst));
        chk("resp_valid", int'(resp_valid[p]), int'(ev));
        chk("rf_check", int'(rf_check[p]), int'(cnt[p] > 0 && !waiting[p] && !ev));
        if (resp_valid[p] && exp_q[p].size() > 0) begin
          chk("resp_id", int'(resp_id[p]), int'(exp_q[p][0][IW-1:0]));
          chk("resp_err", int'(resp_err[p]), int'(exp_q[p][0][IW]));
        end
        if (rf_check[p] && fifo_m[p].size() > 0)
          chk("rf_id", int'(rf_id[p]), int'(fifo_m[p][0]));
        if (rst_prev) begin
          chk("rst_resp_id", int'(resp_id[p]), 0);
          chk("rst_resp_err", int'(resp_err[p]), 0);
          chk("rst_rf_id", int'(rf_id[p]), 0);
        end
      end
    end
    if (rst) begin
      started = 1; rst_prev = 1;
      for (int p = 0; p < NP; p++) begin
        cnt[p] = 0; waiting[p] = 0; rnext[p] = 0; pv[p] = 0; pr[p] = 0;
        fifo_m[p].delete(); exp_q[p].delete();
      end
    end else begin
      rst_prev = 0;
      for (int p = 0; p < NP; p++) nxt[p] = 0;
      // wakes see the waiters as they were at the start of this cycle
      for (int p = 0; p < NP; p++)
        if (rf_check[p] && rf_present[p] && cnt[p] > 0) begin
          hd = fifo_m[p][0];
          for (int q = 0; q < NP; q++)
            if (q != p && waiting[q] && wlid[q] == hd[IW-1:1]) begin
              waiting[q] = 0; nxt[q] = 1;
            end
        end
      for (int p = 0; p < NP; p++)
        if (rf_check[p] && cnt[p] > 0) begin
          hd = fifo_m[p].pop_front();
          cnt[p]--;
          if (rf_id_err[p] || rf_present[p] || rf_bypass[p] || rf_ignore[p]) nxt[p] = 1;
          else begin waiting[p] = 1; wlid[p] = hd[IW-1:1]; end
        end
      for (int p = 0; p < NP; p++)
        if (req_valid[p] && req_ready[p]) begin
          fifo_m[p].push_back(req_id[p]);
          cnt[p]++;
          exp_q[p].push_back({(int'(req_id[p][IW-1:1]) >= NR), req_id[p]});
        end
      for (int p = 0; p < NP; p++)
        if (resp_valid[p] && resp_ready[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
      for (int p = 0; p < NP; p++) begin
        pv[p] = resp_valid[p]; pr[p] = resp_ready[p]; rnext[p] = nxt[p];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  int got[$];
  bit acc, found;

  initial begin
    rst = 1'b1; req_valid = '0; req_id = '0; resp_ready = '1;
    repeat (3) @(posedge clk);
    smp();
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_resp_valid", int'(resp_valid), 0);
    chk("reset_rf_check", int'(rf_check), 0);
    next(); rst = 1'b0;
    smp(); chk("post_reset_ready", int'(req_ready), 7);

    // Port0 id 2 waits; port1 id 3 five cycles later releases both.
    next(); req_valid = 3'b001; req_id[0] = 3'd2;
    next(); req_valid = '0;
    smp(); chk("a_check0", int'(rf_check[0]), 1); chk("a_rfid0", int'(rf_id[0]), 2);
    next(); smp(); chk("a_wait0", int'(resp_valid[0]), 0);
    next(); next(); next(); req_valid = 3'b010; req_id[1] = 3'd3;
    next(); req_valid = '0;
    smp(); chk("a_check1", int'(rf_check[1]), 1);
    next(); smp();
    chk("a_both_valid", int'(resp_valid), 3);
    chk("a_id0", int'(resp_id[0]), 2);
    chk("a_id1", int'(resp_id[1]), 3);
    chk("a_err", int'(resp_err), 0);
    next(); smp(); chk("a_done", int'(resp_valid), 0);

    // Same-cycle pairing on local id 0.
    next(); req_valid = 3'b011; req_id[0] = 3'd0; req_id[1] = 3'd1;
    next(); req_valid = '0;
    smp(); chk("b_check", int'(rf_check), 3);
    next(); smp(); chk("b_valid", int'(resp_valid), 3); chk("b_err", int'(resp_err), 0);
    next(); smp(); chk("b_nowait", int'(resp_valid | rf_check), 0);

    // Out-of-range local id on port0.
    next(); req_valid = 3'b001; req_id[0] = 3'd4;
    next(); req_valid = '0;
    smp(); chk("c_check", int'(rf_check), 1);
    next(); smp();
    chk("c_valid", int'(resp_valid), 1);
    chk("c_err", int'(resp_err[0]), 1);
    chk("c_id", int'(resp_id[0]), 4);

    // Backpressure: responses stalled while FIFO_DEPTH+1 requests arrive.
    next(); resp_ready = '0;
    for (int k = 0; k < FD + 1; k++) begin
      req_valid[0] = 1'b1; req_id[0] = IW'(5 + k); acc = 0;
      for (int w = 0; w < 20 && !acc; w++) begin smp(); acc = req_ready[0]; next(); end
      if (!acc) chk("d_push_timeout", 0, 1);
    end
    req_valid = '0;
    smp(); chk("d_full", int'(req_ready[0]), 0);
    repeat (7) next();
    smp(); chk("d_held_valid", int'(resp_valid[0]), 1); chk("d_held_id", int'(resp_id[0]), 5);
    next(); resp_ready = '1;
    for (int i = 0; i < 12; i++) begin
      smp(); if (resp_valid[0] && resp_ready[0]) got.push_back(int'(resp_id[0]));
      next();
    end
    chk("d_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("d_order0", got[0], 5); chk("d_order1", got[1], 6); chk("d_order2", got[2], 7);
    end

    // Reset while port0 waits; the id is free again afterwards.
    req_valid = 3'b001; req_id[0] = 3'd2;
    next(); req_valid = '0;
    next(); next(); rst = 1'b1;
    next(); next(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin smp(); chk("e_no_resp", int'(resp_valid), 0); next(); end
    req_valid = 3'b010; req_id[1] = 3'd3;
    next(); req_valid = '0;
    smp(); chk("e_check1", int'(rf_check[1]), 1);
    next(); next(); smp(); chk("e_wait1", int'(resp_valid), 0);
    next(); req_valid = 3'b100; req_id[2] = 3'd2;
    next(); req_valid = '0;
    smp(); chk("e_check2", int'(rf_check[2]), 1);
    next(); smp(); chk("e_wake", int'(resp_valid), 6);
    next();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        req_valid[p]  = 1'($urandom_range(0, 1));
        req_id[p]     = IW'($urandom_range(0, 7));
        resp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      next();
    end

    // Drain: release parked ports from an otherwise idle port.
    req_valid = '0; resp_ready = '1;
    repeat (20) next();
    for (int it = 0; it < 20; it++) begin
      found = 0;
      for (int p = 0; p < NP && !found; p++)
        if (waiting[p])
          for (int q = 0; q < NP && !found; q++)
            if (!waiting[q] && cnt[q] == 0 && exp_q[q].size() == 0) begin
              req_valid[q] = 1'b1; req_id[q] = {wlid[p], 1'b0}; found = 1;
            end
      next(); req_valid = '0;
      repeat (10) next();
    end
    for (int p = 0; p < NP; p++) chk("drain_outstanding", exp_q[p].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
